tvip_axi_read_arbiter: RTL and testbench
========================================

# tvip_axi_read_arbiter

Round-robin arbiter that shares one AXI4 read master port between `N_REQUESTERS` read requesters. Each requester sees a full AR/R channel pair. The arbiter serializes AR requests and tags each master-side ARID with the requester index in its upper bits. R beats are routed back to the requester by decoding that tag. It sits between the bench's per-agent AXI master sequencers/drivers and a single `tvip_axi` slave model or DUT port.

## Interface
- `N_REQUESTERS`, 4, number of requester ports (2..16).
- `ID_WIDTH`, 8, requester-side ARID/RID width.
- `ADDRESS_WIDTH`, 32, ARADDR width.
- `DATA_WIDTH`, 64, RDATA width.
- `MAX_OUTSTANDING`, 4, per-requester outstanding-read limit (used only with the configuration macro).
- Derived `IDX_W` = $clog2(N_REQUESTERS). Master ID width is `MID_W` = `ID_WIDTH` + `IDX_W`.

Ports:
- `aclk`, in, 1: clock.
- `areset`, in, 1: synchronous, active-high reset.
- `s_arvalid`, in, N: request valid per requester.
- `s_arready`, out, N: request accept per requester.
- `s_arid`/`s_araddr`/`s_arlen`/`s_arsize`/`s_arburst`/`s_arqos`, in, N×(ID_WIDTH/ADDRESS_WIDTH/8/3/2/4): request payloads, packed with requester i at slice i.
- `s_rvalid`, out, N.
- `s_rready`, in, N.
- `s_rid`/`s_rdata`/`s_rresp`/`s_rlast`, out, ID_WIDTH/DATA_WIDTH/2/1: broadcast to all requesters.
- `m_arvalid`, out, 1.
- `m_arready`, in, 1.
- `m_arid`, out, MID_W.
- `m_araddr`/`m_arlen`/`m_arsize`/`m_arburst`/`m_arqos`, out: registered payload.
- `m_rvalid`, in, 1.
- `m_rready`, out, 1.
- `m_rid`, in, MID_W.
- `m_rdata`/`m_rresp`/`m_rlast`, in.

## Operation
- FSM with two states: IDLE and ISSUE.
- IDLE: choose a winner among eligible `s_arvalid` bits, round-robin starting at `rr_ptr`.
  - Assert `s_arready[winner]` combinationally in the same cycle.
  - Capture the payload into the output register, with `m_arid` = {winner, s_arid}.
  - Go to ISSUE. Set `rr_ptr` to winner+1, wrapping to 0 after N_REQUESTERS-1.
- ISSUE: hold `m_arvalid`=1 with a stable payload until `m_arready`. On the handshake, return to IDLE. No new capture happens in the handshake cycle.
- Only one requester's `s_arready` is high in any cycle.
- R routing:
  - idx = `m_rid[MID_W-1:ID_WIDTH]`.
  - `s_rvalid[i]` = `m_rvalid` && idx==i.
  - `m_rready` = `s_rready[idx]`.
  - `s_rid` = `m_rid[ID_WIDTH-1:0]`.
  - If idx ≥ N_REQUESTERS, `m_rready`=1 and the beat is discarded.
- `s_rresp`/`s_rdata`/`s_rlast` pass straight through, unregistered.

## Timing
- Reset state: FSM=IDLE, `rr_ptr`=0, `m_arvalid`=0, `m_ar*` payload=0, all per-requester counters=0. `s_arready`=0 and `s_rvalid`=0 while `areset` is high.
- AR latency: requester handshake in cycle T gives `m_arvalid`=1 from T+1.
- Peak AR throughput is one request per 2 cycles.
- R path: zero-cycle combinational.
- Simultaneous requests: the lowest index at or after `rr_ptr` wins, so a requester waits at most N_REQUESTERS-1 grants.
- Reset during ISSUE drops the pending request. `m_arvalid` falls in the cycle after `areset` is sampled high.
- Any `s_arvalid` deasserted before its grant is ignored. No error is raised.

## Configuration
- `TVIP_AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN` defined:
  - Each requester has a counter of width $clog2(MAX_OUTSTANDING+1).
  - The counter increments on the requester's `s_ar` handshake and decrements on an R handshake with `rlast`=1 routed to it. Increment and decrement in the same cycle leave it unchanged.
  - A requester whose count equals MAX_OUTSTANDING is ineligible for arbitration.
- Macro undefined: no counters exist, every valid requester is eligible, and the number of outstanding reads is unlimited.

## Test plan
- Single request: requester 2 issues arid=0x5A, araddr=0x1000, len=3. Expect m_arid=0x25A, m_araddr=0x1000, m_arlen=3, and `m_arvalid` one cycle after `s_arready[2]`.
- Contention: all 4 requesters hold valid continuously after reset. Expect grant order 0,1,2,3,0, with grants spaced 2 cycles apart when `m_arready`=1.
- Backpressure: `m_arready` held low for 5 cycles. Expect `m_arvalid` and payload stable, and no `s_arready` pulse until 1 cycle after the handshake.
- R routing: m_rid=0x3A7 with rlast=1 while s_rready[3]=0 for 2 cycles. Expect `s_rvalid` only on bit 3, `m_rready`=0 for 2 cycles, then the handshake, with `s_rid`=0xA7.
- Outstanding limit (macro on, MAX_OUTSTANDING=2): requester 1 issues 2 requests with no R. Expect the third to be blocked. After one rlast beat to requester 1, expect the third to be granted.
- Reset mid-ISSUE: assert `areset` while `m_arvalid`=1. Expect `m_arvalid`=0 the next cycle, and the next grant to go to requester 0.

Source files
------------

// File: rtl/tvip_axi_read_arbiter_if.sv
// Requester-side and master-side AXI4 read channels of the round-robin read arbiter.
// slave: the arbiter's view. master: the view of the requesters plus the downstream slave.
interface tvip_axi_read_arbiter_if #(
  parameter int N_REQUESTERS  = 4,
  parameter int ID_WIDTH      = 8,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 64
);
  localparam int IDX_W = $clog2(N_REQUESTERS);
  localparam int MID_W = ID_WIDTH + IDX_W;

  logic [N_REQUESTERS-1:0]                    s_arvalid;
  logic [N_REQUESTERS-1:0]                    s_arready;
  logic [N_REQUESTERS-1:0][ID_WIDTH-1:0]      s_arid;
  logic [N_REQUESTERS-1:0][ADDRESS_WIDTH-1:0] s_araddr;
  logic [N_REQUESTERS-1:0][7:0]               s_arlen;
  logic [N_REQUESTERS-1:0][2:0]               s_arsize;
  logic [N_REQUESTERS-1:0][1:0]               s_arburst;
  logic [N_REQUESTERS-1:0][3:0]               s_arqos;
  logic [N_REQUESTERS-1:0]                    s_rvalid;
  logic [N_REQUESTERS-1:0]                    s_rready;
  logic [ID_WIDTH-1:0]                        s_rid;
  logic [DATA_WIDTH-1:0]                      s_rdata;
  logic [1:0]                                 s_rresp;
  logic                                       s_rlast;

  logic                     m_arvalid;
  logic                     m_arready;
  logic [MID_W-1:0]         m_arid;
  logic [ADDRESS_WIDTH-1:0] m_araddr;
  logic [7:0]               m_arlen;
  logic [2:0]               m_arsize;
  logic [1:0]               m_arburst;
  logic [3:0]               m_arqos;
  logic                     m_rvalid;
  logic                     m_rready;
  logic [MID_W-1:0]         m_rid;
  logic [DATA_WIDTH-1:0]    m_rdata;
  logic [1:0]               m_rresp;
  logic                     m_rlast;

  modport slave (
    input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arqos, s_rready,
    output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arqos, m_rready,
    input  m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast
  );

  modport master (
    output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arqos, s_rready,
    input  s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    input  m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arqos, m_rready,
    output m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast
  );
endinterface

// File: rtl/tvip_axi_read_arbiter.sv
// Round-robin AXI4 read arbiter: N requesters share one master port, ARID tagged with requester index.
// Optional per-requester outstanding limit: define TVIP_AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN.
module tvip_axi_read_arbiter_lane #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic aclk,
  input  logic areset,
  input  logic sel,
  input  logic m_rvalid,
  input  logic rready,
  input  logic rlast,
  input  logic ar_hs,
  output logic rvalid,
  output logic blocked
);
  assign rvalid = m_rvalid && sel && !areset;

`ifdef TVIP_AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0] cnt;
  logic          done;

  assign done = rvalid && rready && rlast;

  // A stray rlast with nothing outstanding must not wrap the counter.
  always_ff @(posedge aclk) begin
    if (areset)                             cnt <= '0;
    else if (ar_hs && !done)                cnt <= cnt + 1'b1;
    else if (done && !ar_hs && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign blocked = (cnt == CW'(MAX_OUTSTANDING));
`else
  localparam int unused_max = MAX_OUTSTANDING;
  logic unused_lane;
  assign unused_lane = ^{aclk, rready, rlast, ar_hs};
  assign blocked     = 1'b0;
`endif
endmodule

module tvip_axi_read_arbiter #(
  parameter int N_REQUESTERS    = 4,
  parameter int ID_WIDTH        = 8,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                    aclk,
  input logic                    areset,
  tvip_axi_read_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQUESTERS);
  localparam int MID_W = ID_WIDTH + IDX_W;
  localparam int unused_aw = ADDRESS_WIDTH;
  localparam int unused_dw = DATA_WIDTH;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        rr_ptr, winner, cand, r_idx;
  logic [IDX_W:0]          sum;
  logic                    grant, r_hit;
  logic [N_REQUESTERS-1:0] eligible, blocked, ar_hs, rvalid_v;

  assign eligible = bus.s_arvalid & ~blocked;

  // First eligible requester scanning upward from rr_ptr, wrapping at N_REQUESTERS.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    sum    = '0;
    cand   = '0;
    if (state == IDLE && !areset) begin
      for (int k = 0; k < N_REQUESTERS; k++) begin
        sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(N_REQUESTERS)) sum = sum - (IDX_W+1)'(N_REQUESTERS);
        cand = sum[IDX_W-1:0];
        if (!grant && eligible[cand]) begin
          grant  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  assign bus.s_arready = grant ? (N_REQUESTERS'(1) << winner) : '0;
  assign ar_hs         = bus.s_arready & bus.s_arvalid;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      bus.m_arvalid <= 1'b0;
      bus.m_arid    <= '0;
      bus.m_araddr  <= '0;
      bus.m_arlen   <= '0;
      bus.m_arsize  <= '0;
      bus.m_arburst <= '0;
      bus.m_arqos   <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state         <= ISSUE;
          bus.m_arvalid <= 1'b1;
          bus.m_arid    <= {winner, bus.s_arid[winner]};
          bus.m_araddr  <= bus.s_araddr[winner];
          bus.m_arlen   <= bus.s_arlen[winner];
          bus.m_arsize  <= bus.s_arsize[winner];
          bus.m_arburst <= bus.s_arburst[winner];
          bus.m_arqos   <= bus.s_arqos[winner];
          rr_ptr        <= (winner == IDX_W'(N_REQUESTERS-1)) ? '0 : winner + 1'b1;
        end
        ISSUE: if (bus.m_arready) begin
          state         <= IDLE;
          bus.m_arvalid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // R beats are steered by the index tag; unknown tags are drained and dropped.
  assign r_idx        = bus.m_rid[MID_W-1:ID_WIDTH];
  assign r_hit        = {1'b0, r_idx} < (IDX_W+1)'(N_REQUESTERS);
  assign bus.m_rready = r_hit ? bus.s_rready[r_idx] : 1'b1;
  assign bus.s_rid    = bus.m_rid[ID_WIDTH-1:0];
  assign bus.s_rdata  = bus.m_rdata;
  assign bus.s_rresp  = bus.m_rresp;
  assign bus.s_rlast  = bus.m_rlast;
  assign bus.s_rvalid = rvalid_v;

  for (genvar i = 0; i < N_REQUESTERS; i++) begin : g_lane
    tvip_axi_read_arbiter_lane #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_lane (
      .aclk     (aclk),
      .areset   (areset),
      .sel      (r_hit && r_idx == IDX_W'(i)),
      .m_rvalid (bus.m_rvalid),
      .rready   (bus.s_rready[i]),
      .rlast    (bus.m_rlast),
      .ar_hs    (ar_hs[i]),
      .rvalid   (rvalid_v[i]),
      .blocked  (blocked[i])
    );
  end
endmodule

// File: tb/tb_tvip_axi_read_arbiter.sv
// Scoreboard bench for tvip_axi_read_arbiter: grant order, AR payload and R routing.
module tb_tvip_axi_read_arbiter;
  localparam int N = 4, IDW = 8, AW = 32, DW = 64, MO = 2;

  logic aclk = 1'b0;
  logic areset = 1'b1;

  tvip_axi_read_arbiter_if #(.N_REQUESTERS(N), .ID_WIDTH(IDW), .ADDRESS_WIDTH(AW),
                             .DATA_WIDTH(DW)) bus ();

  tvip_axi_read_arbiter #(.N_REQUESTERS(N), .ID_WIDTH(IDW), .ADDRESS_WIDTH(AW),
                          .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [9:0] mid; logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { int req; logic [7:0] rid; logic [63:0] data; } r_t;

  int   n_chk = 0, n_err = 0, cyc = 0;
  ar_t  ar_q[$];
  r_t   r_q[$];
  int   gnt_q[$], gnt_cyc[$], hs_cyc[$];
  logic gnt_prev = 1'b0;
  ar_t  ea;
  r_t   er;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Monitor: pops expectations as the DUT grants, issues and returns beats.
  always @(negedge aclk) begin
    if (areset) gnt_prev = 1'b0;
    else begin
      if (gnt_prev) chk("ar_lat", bus.m_arvalid, 1);
      gnt_prev = |bus.s_arready;
      if (bus.m_arvalid) chk("ar_busy", bus.s_arready, 0);
      if (|bus.s_arready) begin
        gnt_cyc.push_back(cyc);
        if (gnt_q.size() == 0) chk("gnt_unexp", bus.s_arready, 0);
        else chk("gnt_idx", bus.s_arready, 64'(1) << gnt_q.pop_front());
      end
      if (bus.m_arvalid && bus.m_arready) begin
        hs_cyc.push_back(cyc);
        if (ar_q.size() == 0) chk("ar_unexp", ar_q.size(), 1);
        else begin
          ea = ar_q.pop_front();
          chk("m_arid", bus.m_arid, ea.mid);
          chk("m_araddr", bus.m_araddr, ea.addr);
          chk("m_arlen", bus.m_arlen, ea.len);
        end
      end
      if (bus.m_rvalid && bus.m_rready) begin
        if (r_q.size() == 0) chk("r_unexp", r_q.size(), 1);
        else begin
          er = r_q.pop_front();
          chk("s_rvalid", bus.s_rvalid, 64'(1) << er.req);
          chk("s_rid", bus.s_rid, er.rid);
          chk("s_rdata", bus.s_rdata, er.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] id, input logic [31:0] a, input logic [7:0] l);
    bus.s_arid[i] = id; bus.s_araddr[i] = a; bus.s_arlen[i] = l;
    bus.s_arsize[i] = 3'd3; bus.s_arburst[i] = 2'd1; bus.s_arqos[i] = 4'd0;
    bus.s_arvalid[i] = 1'b1;
  endtask

  task automatic expect_ar(input int i, input logic [7:0] id, input logic [31:0] a, input logic [7:0] l);
    ar_t e;
    e.mid = {2'(i), id}; e.addr = a; e.len = l;
    gnt_q.push_back(i);
    ar_q.push_back(e);
  endtask

  task automatic expect_r(input int i, input logic [7:0] id, input logic [63:0] d);
    r_t e;
    e.req = i; e.rid = id; e.data = d;
    r_q.push_back(e);
  endtask

  task automatic wait_grant(input int i);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge aclk);
      if (bus.s_arready[i]) got = 1'b1;
    end
    chk("gnt_wait", 64'(got), 1);
    tick();
    bus.s_arvalid[i] = 1'b0;
  endtask

  task automatic clear_sb();
    ar_q.delete(); r_q.delete(); gnt_q.delete(); gnt_cyc.delete(); hs_cyc.delete();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    bus.s_arvalid = '0; bus.m_rvalid = 1'b0; bus.s_rready = '0;
    tick(); tick();
    clear_sb();
    areset = 1'b0;
  endtask

  task automatic send_r(input int i, input logic [7:0] id, input logic [63:0] d);
    expect_r(i, id, d);
    bus.m_rid = {2'(i), id}; bus.m_rdata = d; bus.m_rresp = 2'd0; bus.m_rlast = 1'b1;
    bus.s_rready = 4'(1) << i;
    bus.m_rvalid = 1'b1;
    tick();
    bus.m_rvalid = 1'b0;
    bus.s_rready = '0;
  endtask

  initial begin
    bus.s_arvalid = '0; bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0;
    bus.s_arsize = '0; bus.s_arburst = '0; bus.s_arqos = '0; bus.s_rready = '0;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rid = '0; bus.m_rdata = '0;
    bus.m_rresp = '0; bus.m_rlast = 1'b0;

    // Reset state, with requests and an R beat presented during reset
    bus.s_arvalid = 4'hF;
    bus.m_rid = 10'h3A7; bus.m_rvalid = 1'b1;
    tick(); tick();
    @(negedge aclk);
    chk("rst_arvalid", bus.m_arvalid, 0);
    chk("rst_arready", bus.s_arready, 0);
    chk("rst_rvalid", bus.s_rvalid, 0);
    chk("rst_arid", bus.m_arid, 0);
    chk("rst_araddr", bus.m_araddr, 0);
    do_reset();

    // Single request from requester 2
    bus.m_arready = 1'b1;
    set_req(2, 8'h5A, 32'h1000, 8'd3);
    expect_ar(2, 8'h5A, 32'h1000, 8'd3);
    wait_grant(2);
    tick(); tick();
    chk("t1_done", ar_q.size(), 0);

    // Contention: all four held valid after reset
    do_reset();
    bus.m_arready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 32'(32'h100 * i), 8'(i));
    for (int i = 0; i < 5; i++) expect_ar(i % N, 8'(8'h10 + i % N), 32'(32'h100 * (i % N)), 8'(i % N));
    for (int k = 0; k < 30 && gnt_cyc.size() < 5; k++) @(negedge aclk);
    tick();
    bus.s_arvalid = '0;
    tick(); tick(); tick();
    chk("t2_ngnt", gnt_cyc.size(), 5);
    if (gnt_cyc.size() >= 5)
      for (int k = 1; k < 5; k++) chk("t2_gap", gnt_cyc[k] - gnt_cyc[k-1], 2);
    chk("t2_done", ar_q.size(), 0);

    // Backpressure: requester 1 then 2 (pointer is at 1), m_arready low for 5 cycles
    gnt_cyc.delete(); hs_cyc.delete();
    bus.m_arready = 1'b0;
    set_req(1, 8'h21, 32'h2000, 8'd1);
    set_req(2, 8'h22, 32'h3000, 8'd2);
    expect_ar(1, 8'h21, 32'h2000, 8'd1);
    expect_ar(2, 8'h22, 32'h3000, 8'd2);
    wait_grant(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("t3_vld", bus.m_arvalid, 1);
      chk("t3_arid", bus.m_arid, 10'h121);
      chk("t3_addr", bus.m_araddr, 32'h2000);
    end
    tick();
    bus.m_arready = 1'b1;
    wait_grant(2);
    tick(); tick();
    if (hs_cyc.size() >= 1 && gnt_cyc.size() >= 2) chk("t3_regrant", gnt_cyc[1] - hs_cyc[0], 1);
    else chk("t3_events", hs_cyc.size() + gnt_cyc.size(), 3);
    chk("t3_done", ar_q.size(), 0);

    // R routing: beat for requester 3 stalled 2 cycles, then one for requester 0
    bus.m_rid = 10'h3A7; bus.m_rdata = 64'hDEAD_BEEF_0123_4567; bus.m_rresp = 2'd0;
    bus.m_rlast = 1'b1; bus.s_rready = '0; bus.m_rvalid = 1'b1;
    expect_r(3, 8'hA7, 64'hDEAD_BEEF_0123_4567);
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      chk("t4_rvalid", bus.s_rvalid, 4'b1000);
      chk("t4_rready", bus.m_rready, 0);
      chk("t4_rid", bus.s_rid, 8'hA7);
    end
    tick();
    bus.s_rready[3] = 1'b1;
    @(negedge aclk);
    chk("t4_hs", bus.m_rready, 1);
    tick();
    bus.m_rvalid = 1'b0; bus.s_rready = '0;
    send_r(0, 8'h11, 64'h0000_1111_2222_3333);
    tick();
    chk("t4_done", r_q.size(), 0);

`ifdef TVIP_AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN
    // Outstanding limit: third request from requester 1 waits for an rlast
    do_reset();
    bus.m_arready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_req(1, 8'(8'h30 + k), 32'(32'h4000 + 32'h40 * k), 8'd0);
      expect_ar(1, 8'(8'h30 + k), 32'(32'h4000 + 32'h40 * k), 8'd0);
      wait_grant(1);
      tick(); tick();
    end
    set_req(1, 8'h32, 32'h4080, 8'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      chk("t5_block", bus.s_arready, 0);
    end
    tick();
    expect_ar(1, 8'h32, 32'h4080, 8'd0);
    send_r(1, 8'h30, 64'h5555);
    wait_grant(1);
    tick(); tick();
    chk("t5_done", ar_q.size(), 0);
`endif

    // Reset while a request is being issued
    bus.m_arready = 1'b0;
    set_req(2, 8'h44, 32'h5000, 8'd0);
    gnt_q.push_back(2);
    wait_grant(2);
    @(negedge aclk);
    chk("t6_issue", bus.m_arvalid, 1);
    tick();
    areset = 1'b1;
    @(negedge aclk);
    chk("t6_hold", bus.m_arvalid, 1);
    @(negedge aclk);
    chk("t6_drop", bus.m_arvalid, 0);
    clear_sb();
    set_req(3, 8'h63, 32'h6300, 8'd1);
    set_req(0, 8'h60, 32'h6000, 8'd2);
    expect_ar(0, 8'h60, 32'h6000, 8'd2);
    expect_ar(3, 8'h63, 32'h6300, 8'd1);
    tick();
    areset = 1'b0;
    bus.m_arready = 1'b1;
    wait_grant(0);
    wait_grant(3);
    tick(); tick(); tick();
    chk("t6_done", ar_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
